// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: holds during memory stalls, defers flushes seen while stalled, freezes after a halt.
// Optional stall-cycle counter enabled by defining EX_MEM_PERF_CNT_EN.
module ex_mem_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] alu_out_in,
    input  logic [15:0] RegData2_in,
    input  logic        MemOp_in,
    input  logic        MemWrite_in,
    input  logic        RegWrite_in,
    input  logic        MemToReg_in,
    input  logic        Halt_in,
    input  logic [3:0]  DstReg_in,
    input  logic        valid_in,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] alu_out,
    output logic [15:0] RegData2,
    output logic        MemOp,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        Halt,
    output logic [3:0]  DstReg,
    output logic        valid,
    output logic        fwd_en,
    output logic        halted
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    typedef enum logic [1:0] {RUN, HOLD, HOLD_FL, HALTED} state_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] alu_out;
        logic [15:0] reg_data2;
        logic        mem_op;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic        halt;
        logic [3:0]  dst_reg;
    } slot_t;

    state_t state_q, state_d;
    slot_t  slot_q, slot_d;
    logic   halted_q, halted_d;
    logic   capture_en;
    logic   kill;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (state_q == HALTED) begin
            state_d = HALTED;
        end else if (stall) begin
            state_d = (flush || state_q == HOLD_FL) ? HOLD_FL : HOLD;
        end else if (flush || state_q == HOLD_FL) begin
            state_d = RUN;
        end else if (valid_in && Halt_in) begin
            state_d = HALTED;
        end else begin
            state_d = RUN;
        end
    end

    // Capture control: a pending or current flush, or an empty EX slot, loads a bubble
    always_comb begin
        capture_en = (state_q != HALTED) && !stall;
        kill       = flush || (state_q == HOLD_FL) || !valid_in;
        slot_d     = '0;
        if (!kill) begin
            slot_d.valid      = 1'b1;
            slot_d.alu_out    = alu_out_in;
            slot_d.reg_data2  = RegData2_in;
            slot_d.mem_op     = MemOp_in;
            slot_d.mem_write  = MemWrite_in;
            slot_d.reg_write  = RegWrite_in;
            slot_d.mem_to_reg = MemToReg_in;
            slot_d.halt       = Halt_in;
            slot_d.dst_reg    = DstReg_in;
        end
        halted_d = halted_q || (capture_en && !kill && Halt_in);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q   <= '0;
            halted_q <= 1'b0;
        end else if (capture_en) begin
            slot_q   <= slot_d;
            halted_q <= halted_d;
        end
    end

`ifdef EX_MEM_PERF_CNT_EN
    logic [15:0] stall_cycles_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= 16'h0000;
        end else if (stall && slot_q.valid && stall_cycles_q != 16'hFFFF) begin
            stall_cycles_q <= stall_cycles_q + 16'h0001;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

    assign valid    = slot_q.valid;
    assign alu_out  = slot_q.alu_out;
    assign RegData2 = slot_q.reg_data2;
    assign MemOp    = slot_q.mem_op;
    assign MemWrite = slot_q.mem_write;
    assign RegWrite = slot_q.reg_write;
    assign MemToReg = slot_q.mem_to_reg;
    assign Halt     = slot_q.halt;
    assign DstReg   = slot_q.dst_reg;
    assign halted   = halted_q;
    assign fwd_en   = slot_q.valid && slot_q.reg_write && (slot_q.dst_reg != 4'd0);

endmodule

// File: tb/tb_ex_mem_reg.sv
// Testbench for ex_mem_reg: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a rule-level model of the pipeline slot.
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] alu_out_in = '0, RegData2_in = '0;
    logic        MemOp_in = 0, MemWrite_in = 0, RegWrite_in = 0, MemToReg_in = 0, Halt_in = 0;
    logic [3:0]  DstReg_in = '0;
    logic        valid_in = 0, stall = 0, flush = 0;
    logic [15:0] alu_out, RegData2;
    logic        MemOp, MemWrite, RegWrite, MemToReg, Halt, valid, fwd_en, halted;
    logic [3:0]  DstReg;
`ifdef EX_MEM_PERF_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int tests  = 0;
    int errors = 0;
    bit check_en = 0;

    always #5 clk = ~clk;

    ex_mem_reg dut (
        .clk(clk), .rst(rst),
        .alu_out_in(alu_out_in), .RegData2_in(RegData2_in),
        .MemOp_in(MemOp_in), .MemWrite_in(MemWrite_in), .RegWrite_in(RegWrite_in),
        .MemToReg_in(MemToReg_in), .Halt_in(Halt_in), .DstReg_in(DstReg_in),
        .valid_in(valid_in), .stall(stall), .flush(flush),
        .alu_out(alu_out), .RegData2(RegData2), .MemOp(MemOp), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .MemToReg(MemToReg), .Halt(Halt), .DstReg(DstReg),
        .valid(valid), .fwd_en(fwd_en), .halted(halted)
`ifdef EX_MEM_PERF_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    // Reference model: what the memory stage should see, from the rules alone
    logic [15:0] m_alu, m_rd2;
    logic        m_mop, m_mw, m_rw, m_m2r, m_halt, m_valid;
    logic [3:0]  m_dst;
    bit          m_halted, m_pend;
    int          m_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            {m_valid, m_alu, m_rd2, m_mop, m_mw, m_rw, m_m2r, m_halt, m_dst} <= '0;
            m_halted <= 0;
            m_pend   <= 0;
            m_cnt    <= 0;
        end else begin
            if (stall && m_valid && m_cnt < 65535) m_cnt <= m_cnt + 1;
            if (m_halted) begin
            end else if (stall) begin
                if (flush) m_pend <= 1;
            end else if (flush || m_pend || !valid_in) begin
                {m_valid, m_alu, m_rd2, m_mop, m_mw, m_rw, m_m2r, m_halt, m_dst} <= '0;
                m_pend <= 0;
            end else begin
                m_valid <= 1; m_alu <= alu_out_in; m_rd2 <= RegData2_in;
                m_mop <= MemOp_in; m_mw <= MemWrite_in; m_rw <= RegWrite_in;
                m_m2r <= MemToReg_in; m_halt <= Halt_in; m_dst <= DstReg_in;
                if (Halt_in) m_halted <= 1;
            end
        end
    end

    wire [43:0] act_v = {valid, alu_out, RegData2, MemOp, MemWrite, RegWrite, MemToReg, Halt, DstReg, halted, fwd_en};
    wire [43:0] exp_v = {m_valid, m_alu, m_rd2, m_mop, m_mw, m_rw, m_m2r, m_halt, m_dst, m_halted,
                         m_valid & m_rw & (m_dst != 4'd0)};

    always @(negedge clk) begin
        if (check_en) begin
            tests++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, act_v, exp_v);
            end
`ifdef EX_MEM_PERF_CNT_EN
            tests++;
            if (stall_cycles !== m_cnt[15:0]) begin
                errors++;
                $display("FAIL model_cnt t=%0t actual=%h required=%h", $time, stall_cycles, m_cnt[15:0]);
            end
`endif
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    // Inputs change at negedge; the following rising edge samples them
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic [15:0] a, input logic [15:0] d, input logic mop, input logic mw,
                          input logic rw, input logic [3:0] dst, input logic hlt, input logic v);
        alu_out_in = a; RegData2_in = d; MemOp_in = mop; MemWrite_in = mw;
        RegWrite_in = rw; MemToReg_in = 0; DstReg_in = dst; Halt_in = hlt; valid_in = v;
    endtask

    initial begin
        // Reset held: activity on inputs must not leak through
        set_in(16'h1234, 16'h0, 1, 0, 0, 4'd0, 0, 1);
        step(); step();
        chk("reset_valid", {15'd0, valid}, 16'd0);
        chk("reset_alu", alu_out, 16'h0000);
        chk("reset_mop", {15'd0, MemOp}, 16'd0);
        rst = 1;
        check_en = 1;
        step();
        chk("cap_alu", alu_out, 16'h1234);
        chk("cap_mop", {15'd0, MemOp}, 16'd1);
        chk("cap_valid", {15'd0, valid}, 16'd1);

        // Stall hold: store stays put with MemWrite steady
        set_in(16'h0040, 16'hBEEF, 1, 1, 0, 4'd0, 0, 1);
        step();
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            set_in(16'h1000 + 16'(i), 16'h5A5A, 0, 0, 1, 4'd7, 0, 1);
            step();
            chk("hold_mw", {15'd0, MemWrite}, 16'd1);
            chk("hold_rd2", RegData2, 16'hBEEF);
        end
        stall = 0;
        step();
        chk("release_alu", alu_out, 16'h1004);
        chk("release_fwd", {15'd0, fwd_en}, 16'd1);

        // Deferred flush
        stall = 1; step();
        flush = 1; step();
        flush = 0; step();
        stall = 0;
        set_in(16'h2222, 16'h3333, 0, 0, 1, 4'd5, 0, 1);
        step();
        chk("defer_bubble", {15'd0, valid}, 16'd0);
        chk("defer_rw", {15'd0, RegWrite}, 16'd0);
        step();
        chk("after_defer", alu_out, 16'h2222);

        // Plain flush
        set_in(16'h7777, 16'h0, 0, 0, 1, 4'd3, 0, 1);
        flush = 1; step(); flush = 0;
        chk("flush_valid", {15'd0, valid}, 16'd0);
        chk("flush_rw", {15'd0, RegWrite}, 16'd0);
        chk("flush_fwd", {15'd0, fwd_en}, 16'd0);

        // Random traffic, no halts
        for (int i = 0; i < 2000; i++) begin
            set_in(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   4'($urandom), 0, ($urandom_range(0, 3) != 0));
            MemToReg_in = 1'($urandom);
            stall = ($urandom_range(0, 9) < 4);
            flush = ($urandom_range(0, 9) < 2);
            step();
        end
        stall = 0; flush = 0;

        // Halt freezes everything until reset
        set_in(16'hABCD, 16'h0, 0, 0, 0, 4'd0, 1, 1);
        step();
        chk("halted", {15'd0, halted}, 16'd1);
        chk("halt_out", {15'd0, Halt}, 16'd1);
        set_in(16'h9999, 16'h1, 1, 1, 1, 4'd9, 0, 1);
        step(); step();
        chk("halt_ignore", alu_out, 16'hABCD);

        // Asynchronous reset between edges
        #2 rst = 0;
        #1;
        chk("async_rst_valid", {15'd0, valid}, 16'd0);
        chk("async_rst_halted", {15'd0, halted}, 16'd0);
        step();
        rst = 1;
        set_in(16'h0101, 16'h0, 0, 0, 0, 4'd0, 0, 1);
        step();
        chk("post_rst_cap", alu_out, 16'h0101);

        // Asynchronous reset during a stall
        stall = 1; step();
        #2 rst = 0;
        #1;
        chk("rst_mid_stall", alu_out, 16'h0000);
        step();
        rst = 1; stall = 0;
        step();

`ifdef EX_MEM_PERF_CNT_EN
        #2 rst = 0; #1;
        step();
        rst = 1;
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) step();
        chk("cnt_three", stall_cycles, 16'd3);
        for (int i = 0; i < 65540; i++) step();
        chk("cnt_sat", stall_cycles, 16'hFFFF);
        stall = 0;
        step();
`endif

        check_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
